// File: rtl/cpu_dcache_ctl.sv
`default_nettype none
//==============================================================================
// Module   : cpu_dcache_ctl
// Brief    : Direct-mapped, write-through, no-write-allocate CPU data cache with
//            burst line refill. Define CACHE_STATS_EN for hit/miss counters.
// Revision : 1.0
//==============================================================================
module cpu_dcache_ctl #(
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 8,
    parameter int LINE_LG    = 1,
    parameter int MEM_ADDR_W = 26
) (
    input  logic                  CPU_CLK,
    input  logic                  RST,
    input  logic                  cpu_en,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  rd_valid,
    output logic                  cpu_busy,
    input  logic                  inv_all,
    input  logic                  dma_mcu_access,
    output logic                  mem_do_act,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    localparam int c_LINE_WORDS = 1 << LINE_LG;
    localparam int c_WORD_W     = (LINE_LG > 0) ? LINE_LG : 1;
    localparam int c_WADDR_W    = ADDR_W - 2;
    localparam int c_TAG_W      = ADDR_W - IDX_W - LINE_LG - 2;
    localparam int c_LINES      = 1 << IDX_W;
    localparam int c_DEPTH      = 1 << (IDX_W + LINE_LG);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_WRITE       = 3'd2,
        ST_REFILL_REQ  = 3'd3,
        ST_REFILL_DATA = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]             r_data_ram [c_DEPTH];
    logic [c_TAG_W-1:0]      r_tag_ram  [c_LINES];
    logic [c_LINES-1:0]      r_valid;

    logic                    r_req_we;
    logic [c_WADDR_W-1:0]    r_req_waddr;
    logic [31:0]             r_req_wdata;
    logic [c_WORD_W-1:0]     r_beat;
    logic [31:0]             r_fill_word;
    logic                    r_inv_pend;

    logic [IDX_W-1:0]        w_idx;
    logic [c_TAG_W-1:0]      w_tag;
    logic [c_WORD_W-1:0]     w_word;
    logic [IDX_W+LINE_LG-1:0] w_ram_idx;
    logic [IDX_W+LINE_LG-1:0] w_fill_ptr;
    logic [MEM_ADDR_W-1:0]   w_mem_word;
    logic [MEM_ADDR_W-1:0]   w_mem_line;
    logic                    w_hit;
    logic                    w_accept;
    logic                    w_beat_fire;
    logic                    w_last_beat;
    logic                    w_fill_done;
    logic                    w_unused;

    assign w_unused   = &{1'b0, cpu_addr[1:0]};

    // The RAM row of a word is simply the low bits of its word address.
    assign w_idx      = r_req_waddr[LINE_LG +: IDX_W];
    assign w_tag      = r_req_waddr[c_WADDR_W-1 -: c_TAG_W];
    assign w_ram_idx  = r_req_waddr[IDX_W+LINE_LG-1:0];
    assign w_mem_word = r_req_waddr[MEM_ADDR_W-1:0];
    assign w_mem_line = w_mem_word & ~MEM_ADDR_W'(c_LINE_WORDS - 1);

    generate
        if (LINE_LG > 0) begin : g_multi_word
            assign w_word     = r_req_waddr[LINE_LG-1:0];
            assign w_fill_ptr = {w_idx, r_beat};
        end else begin : g_single_word
            assign w_word     = 1'b0;
            assign w_fill_ptr = w_idx;
        end
    endgenerate

    assign w_hit       = r_valid[w_idx] && (r_tag_ram[w_idx] == w_tag);
    assign w_beat_fire = (r_state == ST_REFILL_DATA) && mem_rvalid;
    assign w_last_beat = (r_beat == c_WORD_W'(c_LINE_WORDS - 1));
    assign w_fill_done = w_beat_fire && w_last_beat;

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cpu_busy    = 1'b0;
        mem_do_act  = 1'b0;
        mem_we      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_LOOKUP: begin
                if (r_req_we) begin
                    cpu_busy    = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (w_hit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    cpu_busy    = 1'b1;
                    w_state_nxt = ST_REFILL_REQ;
                end
            end
            ST_WRITE: begin
                cpu_busy   = 1'b1;
                mem_do_act = dma_mcu_access;
                mem_we     = 1'b1;
                if (mem_ack && dma_mcu_access) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REFILL_REQ: begin
                cpu_busy   = 1'b1;
                mem_do_act = dma_mcu_access;
                if (mem_ack && dma_mcu_access) begin
                    w_state_nxt = ST_REFILL_DATA;
                end
            end
            ST_REFILL_DATA: begin
                cpu_busy = 1'b1;
                if (w_fill_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (inv_all) begin
            cpu_busy = 1'b1;
        end
        w_accept = cpu_en && !cpu_busy;
        if (w_accept) begin
            w_state_nxt = ST_LOOKUP;
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            r_valid     <= '0;
            rd_valid    <= 1'b0;
            cpu_rdata   <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_req_we    <= 1'b0;
            r_req_waddr <= '0;
            r_req_wdata <= '0;
            r_beat      <= '0;
            r_fill_word <= '0;
            r_inv_pend  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (w_accept) begin
                r_req_we    <= cpu_we;
                r_req_waddr <= cpu_addr[ADDR_W-1:2];
                r_req_wdata <= cpu_wdata;
            end
            case (r_state)
                ST_LOOKUP: begin
                    if (r_req_we) begin
                        mem_addr  <= w_mem_word;
                        mem_wdata <= r_req_wdata;
                    end else if (w_hit) begin
                        rd_valid  <= 1'b1;
                        cpu_rdata <= r_data_ram[w_ram_idx];
                    end else begin
                        mem_addr   <= w_mem_line;
                        r_beat     <= '0;
                        r_inv_pend <= 1'b0;
                    end
                end
                ST_REFILL_DATA: begin
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_word) begin
                            r_fill_word <= mem_rdata;
                        end
                        if (w_last_beat) begin
                            rd_valid  <= 1'b1;
                            cpu_rdata <= (r_beat == w_word) ? mem_rdata : r_fill_word;
                        end
                    end
                end
                default: ;
            endcase
            // An invalidate seen during a refill keeps the incoming line invalid.
            if (inv_all) begin
                r_valid <= '0;
                if (r_state == ST_REFILL_REQ || r_state == ST_REFILL_DATA) begin
                    r_inv_pend <= 1'b1;
                end
            end else if (w_fill_done && !r_inv_pend) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (RST) begin
            if (r_state == ST_LOOKUP && r_req_we && w_hit) begin
                r_data_ram[w_ram_idx] <= r_req_wdata;
            end
            if (w_beat_fire) begin
                r_data_ram[w_fill_ptr] <= mem_rdata;
            end
            if (w_fill_done) begin
                r_tag_ram[w_idx] <= w_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge CPU_CLK) begin
        if (!RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP && !r_req_we) begin
            if (w_hit) begin
                if (hit_cnt != 16'hFFFF) begin
                    hit_cnt <= hit_cnt + 16'd1;
                end
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_dcache_ctl.sv
`default_nettype none
//==============================================================================
// Module   : tb_cpu_dcache_ctl
// Brief    : Directed scoreboard bench for cpu_dcache_ctl (IDX_W=8, LINE_LG=1).
// Revision : 1.0
//==============================================================================
module tb_cpu_dcache_ctl;

    logic        CPU_CLK = 1'b0;
    logic        RST = 1'b0;
    logic        cpu_en = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        rd_valid;
    logic        cpu_busy;
    logic        inv_all = 1'b0;
    logic        dma_mcu_access = 1'b1;
    logic        mem_do_act;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cpu_dcache_ctl #(
        .ADDR_W(32), .IDX_W(8), .LINE_LG(1), .MEM_ADDR_W(26)
    ) dut (
        .CPU_CLK(CPU_CLK), .RST(RST),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .rd_valid(rd_valid), .cpu_busy(cpu_busy),
        .inv_all(inv_all), .dma_mcu_access(dma_mcu_access),
        .mem_do_act(mem_do_act), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 CPU_CLK = ~CPU_CLK;

    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    mem_txn_t    q_mem[$];
    logic [31:0] q_rd[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents read data or an MCU handshake.
    initial begin
        mem_txn_t t;
        logic [31:0] e;
        forever begin
            @(negedge CPU_CLK);
            if (rd_valid) begin
                if (q_rd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_rd_valid: got data 0x%08h, expected no read response", cpu_rdata);
                end else begin
                    e = q_rd.pop_front();
                    check("rd_data", cpu_rdata, e);
                end
            end
            if (mem_do_act && mem_ack) begin
                if (q_mem.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_mcu_req: got addr 0x%07h we %0b, expected no MCU request", mem_addr, mem_we);
                end else begin
                    t = q_mem.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
                    check("mem_addr", {6'd0, mem_addr}, {6'd0, t.addr});
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic cpu_req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int k;
        cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        k = 0;
        @(negedge CPU_CLK);
        while (cpu_busy && k < 50) begin
            @(negedge CPU_CLK);
            k++;
        end
        if (cpu_busy) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: got cpu_busy=1 for 50 cycles, expected 0");
        end
        tick();
        cpu_en = 1'b0;
    endtask

    task automatic mcu_serve(input int nbeats, input logic [31:0] b0, input logic [31:0] b1,
                             input logic exp_rd, input logic inv_beat);
        int k;
        k = 0;
        while (!mem_do_act && k < 50) begin
            tick();
            k++;
        end
        if (!mem_do_act) begin
            n_tests++; n_fail++;
            $display("FAIL mcu_req_timeout: got mem_do_act=0 for 50 cycles, expected 1");
            return;
        end
        check("busy_during_mcu", {31'd0, cpu_busy}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = (i == 0) ? b0 : b1;
            inv_all    = inv_beat && (i == 0);
            tick();
        end
        mem_rvalid = 1'b0;
        inv_all    = 1'b0;
        @(negedge CPU_CLK);
        check("busy_after_mcu", {31'd0, cpu_busy}, 32'd0);
        if (exp_rd) check("rd_valid_after_refill", {31'd0, rd_valid}, 32'd1);
        tick();
    endtask

    task automatic read_miss(input logic [31:0] addr, input logic [25:0] line,
                             input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] exp,
                             input logic inv_beat);
        q_mem.push_back({1'b0, line, 32'd0});
        q_rd.push_back(exp);
        cpu_req(1'b0, addr, 32'd0);
        mcu_serve(2, b0, b1, 1'b1, inv_beat);
    endtask

    task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
        q_rd.push_back(exp);
        cpu_req(1'b0, addr, 32'd0);
        @(negedge CPU_CLK);
        check("hit_busy_lookup", {31'd0, cpu_busy}, 32'd0);
        @(negedge CPU_CLK);
        check("hit_rd_valid", {31'd0, rd_valid}, 32'd1);
        tick();
    endtask

    task automatic write_thru(input logic [31:0] addr, input logic [31:0] wd, input logic [25:0] waddr);
        q_mem.push_back({1'b1, waddr, wd});
        cpu_req(1'b1, addr, wd);
        mcu_serve(0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"},   {31'd0, rd_valid},   32'd0);
        check({tag, "_cpu_busy"},   {31'd0, cpu_busy},   32'd0);
        check({tag, "_mem_do_act"}, {31'd0, mem_do_act}, 32'd0);
        check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        check({tag, "_cpu_rdata"},  cpu_rdata,           32'd0);
        check({tag, "_mem_addr"},   {6'd0, mem_addr},    32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef CACHE_STATS_EN
        logic [15:0] miss0;
`endif
        repeat (3) tick();
        @(negedge CPU_CLK);
        check_reset_outputs("reset");
`ifdef CACHE_STATS_EN
        check("reset_hit_cnt",  {16'd0, hit_cnt},  32'd0);
        check("reset_miss_cnt", {16'd0, miss_cnt}, 32'd0);
`endif
        tick();
        RST = 1'b1;
        tick();

        // Cold miss, then hit on the other word of the line
        read_miss(32'h0000_0104, 26'h000040, 32'hA0, 32'hA1, 32'hA1, 1'b0);
        read_hit(32'h0000_0100, 32'hA0);

        // Back-to-back hits accepted on consecutive edges
        q_rd.push_back(32'hA0);
        q_rd.push_back(32'hA1);
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
        @(negedge CPU_CLK);
        check("b2b_first_busy", {31'd0, cpu_busy}, 32'd0);
        tick();
        cpu_addr = 32'h0000_0104;
        @(negedge CPU_CLK);
        check("b2b_second_busy", {31'd0, cpu_busy}, 32'd0);
        tick();
        cpu_en = 1'b0;
        @(negedge CPU_CLK);
        check("b2b_rd_valid_1", {31'd0, rd_valid}, 32'd1);
        tick();
        @(negedge CPU_CLK);
        check("b2b_rd_valid_2", {31'd0, rd_valid}, 32'd1);
        tick();

        // Write hit updates the cache and goes through to memory
        write_thru(32'h0000_0104, 32'hDEAD_BEEF, 26'h000041);
        read_hit(32'h0000_0104, 32'hDEAD_BEEF);

        // Conflict miss evicts, write miss does not allocate
        read_miss(32'h0000_0904, 26'h000240, 32'hB0, 32'hB1, 32'hB1, 1'b0);
        read_miss(32'h0000_0104, 26'h000040, 32'hA0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        write_thru(32'h0000_2000, 32'h1234_5678, 26'h000800);
        read_miss(32'h0000_2000, 26'h000800, 32'h1234_5678, 32'h55, 32'h1234_5678, 1'b0);

        // Grant withheld for 5 cycles in REFILL_REQ
        dma_mcu_access = 1'b0;
        q_mem.push_back({1'b0, 26'h000400, 32'd0});
        q_rd.push_back(32'h11);
        cpu_req(1'b0, 32'h0000_1000, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge CPU_CLK);
            check("stall_mem_do_act", {31'd0, mem_do_act}, 32'd0);
            check("stall_busy", {31'd0, cpu_busy}, 32'd1);
            tick();
        end
        dma_mcu_access = 1'b1;
        @(negedge CPU_CLK);
        check("stall_regrant_act", {31'd0, mem_do_act}, 32'd1);
        check("stall_regrant_addr", {6'd0, mem_addr}, 32'h0000_0400);
        tick();
        mcu_serve(2, 32'h11, 32'h22, 1'b1, 1'b0);

        // Top-of-memory line wraps within the MCU word space
        read_miss(32'hFFFF_FFFC, 26'h3FF_FFFE, 32'hE0, 32'hE1, 32'hE1, 1'b0);
        read_hit(32'hFFFF_FFF8, 32'hE0);

        // inv_all beats a simultaneous request, then the line misses
`ifdef CACHE_STATS_EN
        miss0 = miss_cnt;
`endif
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100; inv_all = 1'b1;
        @(negedge CPU_CLK);
        check("inv_busy", {31'd0, cpu_busy}, 32'd1);
        tick();
        inv_all = 1'b0;
        read_miss(32'h0000_0100, 26'h000040, 32'hA0, 32'hDEAD_BEEF, 32'hA0, 1'b0);
`ifdef CACHE_STATS_EN
        check("inv_miss_cnt", {16'd0, miss_cnt}, {16'd0, miss0 + 16'd1});
`endif

        // inv_all during refill: data still returned, line left invalid
        read_miss(32'h0000_0904, 26'h000240, 32'hB0, 32'hB1, 32'hB1, 1'b1);
        read_miss(32'h0000_0904, 26'h000240, 32'hB0, 32'hB1, 32'hB1, 1'b0);

        // Reset after the first refill beat
        q_mem.push_back({1'b0, 26'h000C00, 32'd0});
        cpu_req(1'b0, 32'h0000_3000, 32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_rvalid = 1'b0;
        RST = 1'b0;
        tick();
        RST = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h88; mem_ack = 1'b1;
        @(negedge CPU_CLK);
        check_reset_outputs("midrst");
        tick();
        mem_rvalid = 1'b0; mem_ack = 1'b0;
        @(negedge CPU_CLK);
        check("stray_rd_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        read_miss(32'h0000_3000, 26'h000C00, 32'h99, 32'hAA, 32'h99, 1'b0);

        repeat (3) tick();
        check("queues_drained", q_rd.size() + q_mem.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
